// File: rtl/instr_loader_pkg.sv
// -----------------------------------------------------------------------------
// instr_loader_pkg
// Shared definitions for the instruction loader and the control decoder:
//   - kind_e    : symbolic instruction kinds accepted on the request port
//   - OP_* / FN_*: MIPS opcode and funct field values
//   - state_e   : loader session states
//   - r_word / i_word: field-packing helpers for R- and I-format words
// -----------------------------------------------------------------------------
package instr_loader_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    SLT  = 4'd4,
    LW   = 4'd5,
    SW   = 4'd6,
    ADDI = 4'd7,
    ORI  = 4'd8,
    BEQ  = 4'd9,
    BNE  = 4'd10,
    J    = 4'd11
  } kind_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, 5'b0, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encode.sv
// -----------------------------------------------------------------------------
// instr_encode
// Purely combinational MIPS instruction assembler.
// Ports:
//   i_kind      instruction kind code (kind_e values; 12-15 are illegal)
//   i_rs/rt/rd  register fields
//   i_imm       16-bit immediate / branch offset
//   i_target    26-bit jump target
//   o_word      assembled 32-bit instruction (0 when illegal)
//   o_illegal   kind code is not a supported instruction
// -----------------------------------------------------------------------------
module instr_encode
  import instr_loader_pkg::*;
(
  input  logic [3:0]  i_kind,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_target,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    o_word    = '0;
    o_illegal = 1'b0;
    case (i_kind)
      ADD:     o_word = r_word(i_rs, i_rt, i_rd, FN_ADD);
      SUB:     o_word = r_word(i_rs, i_rt, i_rd, FN_SUB);
      AND:     o_word = r_word(i_rs, i_rt, i_rd, FN_AND);
      OR:      o_word = r_word(i_rs, i_rt, i_rd, FN_OR);
      SLT:     o_word = r_word(i_rs, i_rt, i_rd, FN_SLT);
      LW:      o_word = i_word(OP_LW,   i_rs, i_rt, i_imm);
      SW:      o_word = i_word(OP_SW,   i_rs, i_rt, i_imm);
      ADDI:    o_word = i_word(OP_ADDI, i_rs, i_rt, i_imm);
      ORI:     o_word = i_word(OP_ORI,  i_rs, i_rt, i_imm);
      BEQ:     o_word = i_word(OP_BEQ,  i_rs, i_rt, i_imm);
      BNE:     o_word = i_word(OP_BNE,  i_rs, i_rt, i_imm);
      J:       o_word = {OP_J, i_target};
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
// Assembles symbolic instruction requests into MIPS words and writes them
// sequentially into instruction memory, starting at a programmable base.
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN adds a 32-bit XOR checksum
// of all words written in the session.
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   start               begin a session (IDLE only); samples base_addr, count
//   base_addr, count    first word address, number of legal words to write
//   req_valid/ready     request handshake
//   req_kind, req_rs, req_rt, req_rd, req_imm, req_target  request fields
//   imem_we/waddr/wdata registered imem write port (one cycle after handshake)
//   busy                session is accepting requests (LOAD)
//   done                one-cycle pulse at session end
//   err_illegal         sticky: illegal kind seen (cleared on start)
//   err_wrap            sticky: address wrapped past the top (cleared on start)
//   checksum            (macro only) XOR of every word written this session
// -----------------------------------------------------------------------------
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_kind,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_wrap
`ifdef INSTR_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  state_e            r_state, w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_remaining;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;
  logic              r_done_zero;
  logic              r_err_illegal;
  logic              r_err_wrap;

  logic [31:0]       w_word;
  logic              w_illegal;
  logic              w_hs;
  logic              w_legal_write;
  logic              w_idle_start;

  instr_encode u_encode (
    .i_kind    (req_kind),
    .i_rs      (req_rs),
    .i_rt      (req_rt),
    .i_rd      (req_rd),
    .i_imm     (req_imm),
    .i_target  (req_target),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  assign req_ready     = (r_state == LOAD) && (r_remaining != '0);
  assign w_hs          = req_valid && req_ready;
  // Illegal requests complete the handshake but are dropped.
  assign w_legal_write = w_hs && !w_illegal;
  assign w_idle_start  = start && (r_state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    // A zero-count session never leaves IDLE; it only pulses done.
    done         = r_done_zero;
    case (r_state)
      IDLE: begin
        if (w_idle_start && (count != '0)) w_next_state = LOAD;
      end
      LOAD: begin
        busy = 1'b1;
        if (w_legal_write && (r_remaining == CNT_W'(1))) w_next_state = FLUSH;
      end
      FLUSH: begin
        // The last word is on the imem port during this cycle.
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr        <= '0;
      r_remaining   <= '0;
      r_we          <= 1'b0;
      r_waddr       <= '0;
      r_wdata       <= '0;
      r_done_zero   <= 1'b0;
      r_err_illegal <= 1'b0;
      r_err_wrap    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      r_we        <= w_legal_write;
      r_done_zero <= w_idle_start && (count == '0);
      if (w_idle_start) begin
        r_addr        <= base_addr;
        r_remaining   <= count;
        r_err_illegal <= 1'b0;
        r_err_wrap    <= 1'b0;
      end else if (w_hs) begin
        if (w_illegal) begin
          r_err_illegal <= 1'b1;
        end else begin
          r_waddr     <= r_addr;
          r_wdata     <= w_word;
          r_addr      <= r_addr + ADDR_W'(1);
          r_remaining <= r_remaining - CNT_W'(1);
          if (&r_addr) r_err_wrap <= 1'b1;
        end
      end
    end
  end

  assign imem_we     = r_we;
  assign imem_waddr  = r_waddr;
  assign imem_wdata  = r_wdata;
  assign err_illegal = r_err_illegal;
  assign err_wrap    = r_err_wrap;

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              r_checksum <= '0;
    else if (w_idle_start)  r_checksum <= '0;
    else if (w_legal_write) r_checksum <= r_checksum ^ w_word;
  end

  assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
// Directed scenarios with literal expectations followed by randomized sessions.
// A session-level reference model predicts every cycle's outputs; one compare
// process checks the DUT against it on each falling edge.
// -----------------------------------------------------------------------------
module tb_instr_loader;

  localparam int AW = 6;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] count = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    req_kind = '0;
  logic [4:0]    req_rs = '0, req_rt = '0, req_rd = '0;
  logic [15:0]   req_imm = '0;
  logic [25:0]   req_target = '0;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          busy, done, err_illegal, err_wrap;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  instr_loader #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .count       (count),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_kind    (req_kind),
    .req_rs      (req_rs),
    .req_rt      (req_rt),
    .req_rd      (req_rd),
    .req_imm     (req_imm),
    .req_target  (req_target),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .busy        (busy),
    .done        (done),
    .err_illegal (err_illegal),
    .err_wrap    (err_wrap)
`ifdef INSTR_LOADER_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_writes = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Opcode per kind (R-types share 0) and funct per R-type kind.
  localparam logic [5:0] OPC [12] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h23,
                                      6'h2B, 6'h08, 6'h0D, 6'h04, 6'h05, 6'h02};
  localparam logic [5:0] FNC [5]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  function automatic logic [31:0] ref_word(input int kind, input int rs, input int rt,
                                           input int rd, input int imm, input int tgt);
    logic [31:0] op;
    op = 32'(OPC[kind]);
    if (kind < 5)   return 32'(rs * 2**21 + rt * 2**16 + rd * 2**11) | 32'(FNC[kind]);
    if (kind == 11) return op * 2**26 + 32'(tgt);
    return op * 2**26 + 32'(rs * 2**21 + rt * 2**16 + imm);
  endfunction

  int          m_rem, m_addr;
  bit          m_flush, m_ill, m_wrap;
  logic [31:0] m_cks;
  bit          e_we, e_done;
  int          e_waddr;
  logic [31:0] e_wdata;

  task automatic model_reset();
    m_rem = 0; m_addr = 0; m_flush = 0; m_ill = 0; m_wrap = 0; m_cks = '0;
    e_we = 0; e_done = 0; e_waddr = 0; e_wdata = '0;
  endtask

  // Advance the model across one rising edge using the inputs held before it.
  task automatic model_step();
    bit idle, hs;
    logic [31:0] w;
    if (reset) begin
      model_reset();
      return;
    end
    idle    = (m_rem == 0) && !m_flush;
    hs      = req_valid && (m_rem != 0);
    e_we    = 0;
    e_done  = 0;
    m_flush = 0;
    if (hs) begin
      if (int'(req_kind) >= 12) begin
        m_ill = 1;
      end else begin
        w = ref_word(int'(req_kind), int'(req_rs), int'(req_rt), int'(req_rd),
                     int'(req_imm), int'(req_target));
        e_we    = 1;
        e_waddr = m_addr;
        e_wdata = w;
        m_cks   = m_cks ^ w;
        if (m_addr == 2**AW - 1) m_wrap = 1;
        m_addr = (m_addr + 1) % (2**AW);
        m_rem--;
        if (m_rem == 0) begin
          e_done  = 1;
          m_flush = 1;
        end
      end
    end else if (start && idle) begin
      m_addr = int'(base_addr);
      m_rem  = int'(count);
      m_ill  = 0;
      m_wrap = 0;
      m_cks  = '0;
      if (count == '0) e_done = 1;
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (imem_we) n_writes++;
    if (chk_en) begin
      check("m_we",      32'(imem_we),     32'(e_we));
      check("m_busy",    32'(busy),        32'(m_rem != 0));
      check("m_ready",   32'(req_ready),   32'(m_rem != 0));
      check("m_done",    32'(done),        32'(e_done));
      check("m_err_ill", 32'(err_illegal), 32'(m_ill));
      check("m_err_wrp", 32'(err_wrap),    32'(m_wrap));
      if (e_we) begin
        check("m_waddr", 32'(imem_waddr), 32'(e_waddr));
        check("m_wdata", imem_wdata,      e_wdata);
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      if (e_done) check("m_cks", checksum, m_cks);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    start     = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic start_session(input int b, input int c);
    base_addr = AW'(b);
    count     = CW'(c);
    start     = 1'b1;
    tick();
  endtask

  task automatic send(input int k, input int rs, input int rt, input int rd,
                      input int imm, input int tgt);
    req_valid  = 1'b1;
    req_kind   = 4'(k);
    req_rs     = 5'(rs);
    req_rt     = 5'(rt);
    req_rd     = 5'(rd);
    req_imm    = 16'(imm);
    req_target = 26'(tgt);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    32'(imem_we),     32'd0);
    check({tag, "_waddr"}, 32'(imem_waddr),  32'd0);
    check({tag, "_wdata"}, imem_wdata,       32'd0);
    check({tag, "_busy"},  32'(busy),        32'd0);
    check({tag, "_done"},  32'(done),        32'd0);
    check({tag, "_ready"}, 32'(req_ready),   32'd0);
    check({tag, "_ill"},   32'(err_illegal), 32'd0);
    check({tag, "_wrap"},  32'(err_wrap),    32'd0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int w0, guard;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    reset = 1'b0;
    chk_en = 1'b1;

    // Single R-type word at address 0.
    start_session(0, 1);
    send(0, 1, 2, 3, 0, 0);
    check("s1_we",    32'(imem_we),    32'd1);
    check("s1_waddr", 32'(imem_waddr), 32'd0);
    check("s1_wdata", imem_wdata,      32'h00221820);
    check("s1_done",  32'(done),       32'd1);
    tick();
    check("s1_done_end", 32'(done), 32'd0);

    // Back-to-back lw / ori / j.
    start_session(4, 3);
    send(5, 0, 2, 0, 4, 0);
    check("s2_w0",  imem_wdata, 32'h8C020004);
    check("s2_a0",  32'(imem_waddr), 32'd4);
    send(8, 0, 5, 0, 16'h00FF, 0);
    check("s2_w1",  imem_wdata, 32'h340500FF);
    check("s2_a1",  32'(imem_waddr), 32'd5);
    check("s2_rdy", 32'(req_ready), 32'd1);
    send(11, 0, 0, 0, 0, 32'h10);
    check("s2_w2",  imem_wdata, 32'h08000010);
    check("s2_a2",  32'(imem_waddr), 32'd6);
    check("s2_rdy_off", 32'(req_ready), 32'd0);
`ifdef INSTR_LOADER_CHECKSUM_EN
    check("s2_cks", checksum, 32'h8C020004 ^ 32'h340500FF ^ 32'h08000010);
`endif
    tick();

    // Illegal kind in the middle is dropped.
    w0 = n_writes;
    start_session(10, 2);
    send(9, 1, 2, 0, 16'hFFFF, 0);
    check("s3_w0", imem_wdata, 32'h1022FFFF);
    check("s3_a0", 32'(imem_waddr), 32'd10);
    send(13, 7, 7, 7, 16'h1234, 0);
    check("s3_ill_we", 32'(imem_we), 32'd0);
    check("s3_ill",    32'(err_illegal), 32'd1);
    send(6, 3, 4, 0, 8, 0);
    check("s3_w1", imem_wdata, 32'hAC640008);
    check("s3_a1", 32'(imem_waddr), 32'd11);
    tick();
    check("s3_nwrites", 32'(n_writes - w0), 32'd2);

    // Address wrap from 63 to 0.
    start_session(63, 2);
    check("s4_wrap_clr", 32'(err_wrap), 32'd0);
    send(7, 1, 1, 0, 1, 0);
    check("s4_a0", 32'(imem_waddr), 32'd63);
    send(7, 1, 1, 0, 2, 0);
    check("s4_a1",   32'(imem_waddr), 32'd0);
    check("s4_wrap", 32'(err_wrap),   32'd1);
    tick();

    // Zero-count session pulses done without becoming busy.
    start_session(5, 0);
    check("s0_done", 32'(done), 32'd1);
    check("s0_busy", 32'(busy), 32'd0);
    tick();

    // Start during LOAD is ignored.
    start_session(8, 2);
    start_session(40, 1);
    send(0, 1, 1, 1, 0, 0);
    check("s6_addr", 32'(imem_waddr), 32'd8);
    send(0, 1, 1, 1, 0, 0);
    tick();

    // Asynchronous reset mid-session.
    start_session(20, 4);
    send(7, 2, 2, 0, 5, 0);
    check("s5_we", 32'(imem_we), 32'd1);
    reset = 1'b1;
    #1;
    model_reset();
    check_all_zero("s5_rst");
    tick();
    tick();
    reset = 1'b0;
    start_session(30, 1);
    send(3, 5, 6, 7, 0, 0);
    check("s5_after_a", 32'(imem_waddr), 32'd30);
    check("s5_after_w", imem_wdata, 32'h00A63825);
    tick();

    // Randomized sessions.
    for (int s = 0; s < 40; s++) begin
      start_session(int'($urandom_range(0, 63)), int'($urandom_range(0, 6)));
      guard = 0;
      while ((m_rem != 0 || m_flush) && guard < 300) begin
        req_valid  = ($urandom_range(0, 9) < 7);
        req_kind   = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 11))
                                                : 4'($urandom_range(12, 15));
        req_rs     = 5'($urandom);
        req_rt     = 5'($urandom);
        req_rd     = 5'($urandom);
        req_imm    = 16'($urandom);
        req_target = 26'($urandom);
        start      = ($urandom_range(0, 19) == 0);
        base_addr  = AW'($urandom);
        count      = CW'($urandom_range(0, 6));
        tick();
        guard++;
      end
      check("rand_bound", 32'(guard < 300), 32'd1);
      tick();
    end

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
